// File: rtl/bowling_multi_scorer_if.sv
// Roll/score bus between the lane pin-counter front end, the multi-player
// scorer and the scoreboard display logic. The front end side is the master.
interface bowling_multi_scorer_if #(
    parameter int PLAYER_W = 2,
    parameter int FRAME_W  = 4,
    parameter int PIN_W    = 4,
    parameter int SCORE_W  = 9
);
    logic                new_game;
    logic                roll;
    logic [PIN_W-1:0]    pin_count;
    logic [PLAYER_W-1:0] score_sel;
    logic [SCORE_W-1:0]  score;
    logic                roll_error;
    logic [PLAYER_W-1:0] cur_player;
    logic [FRAME_W-1:0]  cur_frame;
    logic [1:0]          cur_ball;
    logic                game_over;

    modport master (
        output new_game, roll, pin_count, score_sel,
        input  score, roll_error, cur_player, cur_frame, cur_ball, game_over
    );

    modport slave (
        input  new_game, roll, pin_count, score_sel,
        output score, roll_error, cur_player, cur_frame, cur_ball, game_over
    );
endinterface

// File: rtl/bowling_multi_scorer.sv
// Multi-player bowling scorer. Every accepted roll adds its weighted pin
// count to the roller's running total straight away; pending strike/spare
// bonuses are carried as two per-player multipliers, so no end-of-game
// scoring pass is needed. Turn order rotates players frame by frame.
module bowling_multi_scorer #(
    parameter int PLAYERS  = 4,
    parameter int PLAYER_W = 2,
    parameter int FRAMES   = 10,
    parameter int FRAME_W  = 4,
    parameter int PINS     = 10,
    parameter int PIN_W    = 4,
    parameter int SCORE_W  = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    bowling_multi_scorer_if.slave  bus
);

    // Per-player running state
    logic [SCORE_W-1:0]  total_q [PLAYERS];
    logic [SCORE_W-1:0]  total_d [PLAYERS];
    logic [1:0]          m1_q    [PLAYERS];
    logic [1:0]          m1_d    [PLAYERS];
    logic [1:0]          m2_q    [PLAYERS];
    logic [1:0]          m2_d    [PLAYERS];

    // Position within the game; the frame in progress belongs to player_q,
    // so the standing-pin count and final-frame strike flag are shared.
    logic [PLAYER_W-1:0] player_q,   player_d;
    logic [FRAME_W-1:0]  frame_q,    frame_d;
    logic [1:0]          ball_q,     ball_d;
    logic [PIN_W-1:0]    standing_q, standing_d;
    logic                strike1_q,  strike1_d;
    logic                over_q,     over_d;
    logic                err_q,      err_d;
    logic [SCORE_W-1:0]  score_q,    score_d;

    // Decoded view of the current roll
    logic [SCORE_W-1:0]  cur_total;
    logic [1:0]          cur_m1;
    logic [1:0]          cur_m2;
    logic                is_last;
    logic                bonus_ball;
    logic                is_strike;
    logic                is_spare;
    logic                frame_end;
    logic                accept;
    logic                reject;
    logic [1:0]          factor;

    // Pins weighted by 0..3 using shift-and-add rather than a multiplier.
    function automatic logic [SCORE_W-1:0] weighted_pins(
        input logic [PIN_W-1:0] n,
        input logic [1:0]       f
    );
        logic [SCORE_W-1:0] n_ext;
        logic [SCORE_W-1:0] acc;
        n_ext = SCORE_W'(n);
        acc   = '0;
        if (f[0]) acc = acc + n_ext;
        if (f[1]) acc = acc + (n_ext << 1);
        return acc;
    endfunction

    // Roll validation, scoring, multiplier update and turn advance
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            total_d[p] = total_q[p];
            m1_d[p]    = m1_q[p];
            m2_d[p]    = m2_q[p];
        end
        player_d   = player_q;
        frame_d    = frame_q;
        ball_d     = ball_q;
        standing_d = standing_q;
        strike1_d  = strike1_q;
        over_d     = over_q;
        err_d      = 1'b0;
        score_d    = '0;

        cur_total = '0;
        cur_m1    = '0;
        cur_m2    = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (player_q == PLAYER_W'(p)) begin
                cur_total = total_q[p];
                cur_m1    = m1_q[p];
                cur_m2    = m2_q[p];
            end
        end

        // Registered score view; selects beyond the last player read as 0.
        for (int p = 0; p < PLAYERS; p++) begin
            if (bus.score_sel == PLAYER_W'(p)) begin
                score_d = total_q[p];
            end
        end

        is_last    = (frame_q == FRAME_W'(FRAMES));
        // Balls thrown after a mark in the final frame only pay off bonuses.
        bonus_ball = is_last && ((ball_q == 2'd3) || ((ball_q == 2'd2) && strike1_q));
        is_strike  = !bonus_ball && (ball_q == 2'd1) && (bus.pin_count == PIN_W'(PINS));
        is_spare   = !bonus_ball && (ball_q == 2'd2) && (bus.pin_count == standing_q);
        factor     = (bonus_ball ? 2'd0 : 2'd1) + cur_m1;

        if (is_last) begin
            frame_end = (ball_q == 2'd3) ||
                        ((ball_q == 2'd2) && !strike1_q && !is_spare);
        end else begin
            frame_end = is_strike || (ball_q == 2'd2);
        end

        accept = bus.roll && !bus.new_game && !over_q && (bus.pin_count <= standing_q);
        reject = bus.roll && !bus.new_game && (over_q || (bus.pin_count > standing_q));

        if (bus.new_game) begin
            for (int p = 0; p < PLAYERS; p++) begin
                total_d[p] = '0;
                m1_d[p]    = '0;
                m2_d[p]    = '0;
            end
            player_d   = '0;
            frame_d    = FRAME_W'(1);
            ball_d     = 2'd1;
            standing_d = PIN_W'(PINS);
            strike1_d  = 1'b0;
            over_d     = 1'b0;
            score_d    = '0;
        end else begin
            err_d = reject;
            if (accept) begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (player_q == PLAYER_W'(p)) begin
                        total_d[p] = cur_total + weighted_pins(bus.pin_count, factor);
                        m1_d[p]    = cur_m2 + ((is_strike || is_spare) ? 2'd1 : 2'd0);
                        m2_d[p]    = is_strike ? 2'd1 : 2'd0;
                    end
                end

                if (frame_end) begin
                    ball_d     = 2'd1;
                    standing_d = PIN_W'(PINS);
                    strike1_d  = 1'b0;
                    if (player_q == PLAYER_W'(PLAYERS - 1)) begin
                        if (is_last) begin
                            // Game complete: position freezes where it is.
                            ball_d = ball_q;
                            over_d = 1'b1;
                        end else begin
                            player_d = '0;
                            frame_d  = frame_q + FRAME_W'(1);
                        end
                    end else begin
                        player_d = player_q + PLAYER_W'(1);
                    end
                end else begin
                    ball_d = ball_q + 2'd1;
                    // Only the final frame re-racks mid-frame after a mark.
                    if (bus.pin_count == standing_q) begin
                        standing_d = PIN_W'(PINS);
                    end else begin
                        standing_d = standing_q - bus.pin_count;
                    end
                    if (ball_q == 2'd1) begin
                        strike1_d = is_last && is_strike;
                    end
                end
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < PLAYERS; p++) begin
                total_q[p] <= '0;
                m1_q[p]    <= '0;
                m2_q[p]    <= '0;
            end
            player_q   <= '0;
            frame_q    <= FRAME_W'(1);
            ball_q     <= 2'd1;
            standing_q <= PIN_W'(PINS);
            strike1_q  <= 1'b0;
            over_q     <= 1'b0;
            err_q      <= 1'b0;
            score_q    <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                total_q[p] <= total_d[p];
                m1_q[p]    <= m1_d[p];
                m2_q[p]    <= m2_d[p];
            end
            player_q   <= player_d;
            frame_q    <= frame_d;
            ball_q     <= ball_d;
            standing_q <= standing_d;
            strike1_q  <= strike1_d;
            over_q     <= over_d;
            err_q      <= err_d;
            score_q    <= score_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.roll_error = err_q;
    assign bus.cur_player = player_q;
    assign bus.cur_frame  = frame_q;
    assign bus.cur_ball   = ball_q;
    assign bus.game_over  = over_q;

endmodule

// File: doc/bowling_multi_scorer.md
# bowling_multi_scorer

Parametrised, multi-player successor to the single-game bowling scorer. It accepts one roll per strobe, rotates turns between players frame by frame, and validates every pin count against the frame rules. It keeps a running total per player, updated on every roll with no separate scoring pass. It sits between the lane pin-counter front end and the scoreboard display logic.

## Interface
- PLAYERS, 4: number of players; must be ≥1.
- PLAYER_W, 2: width of player indices; must be ≥1 and 2^PLAYER_W ≥ PLAYERS.
- FRAMES, 10: frames per game; must be ≥2.
- FRAME_W, 4: width of `cur_frame`; must hold FRAMES.
- PINS, 10: pins per rack.
- PIN_W, 4: width of `pin_count`; must hold PINS.
- SCORE_W, 9: score width; must hold 3·PINS·FRAMES (300 at defaults).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- new_game  in  1  synchronous clear, same effect as reset; has priority over `roll`.
- roll  in  1  each cycle sampled high is one roll.
- pin_count  in  PIN_W  pins knocked down, sampled with `roll`.
- score_sel  in  PLAYER_W  player whose total drives `score`.
- score  out  SCORE_W  registered running total of player `score_sel`.
- roll_error  out  1  one-cycle pulse: the roll was rejected.
- cur_player  out  PLAYER_W  player to roll next.
- cur_frame  out  FRAME_W  frame to roll next, 1-based.
- cur_ball  out  2  ball within the frame: 1, 2 or 3.
- game_over  out  1  high once the last player finishes the last frame.

## Operation
- Per-player state:
  - total[p] (SCORE_W bits)
  - two bonus multipliers m1[p] and m2[p], each 0..2
  - frame state: first-ball pins and, for the final frame, the mark/strike status
- Accepted roll of pins `n` by player p (base=1 in frames 1..FRAMES-1 and for the first two balls of the final frame; base=0 for final-frame bonus balls):
  - total += n·(base + m1)
  - then m1 ← m2 and m2 ← 0
  - then, if the roll is not a final-frame bonus ball: a strike adds 1 to m1 and 1 to m2; a spare adds 1 to m1.
- Legality, frames 1..FRAMES-1:
  - ball1 ≤ PINS
  - ball2 ≤ PINS−ball1
  - a strike ends the frame; otherwise the frame ends after ball2.
- Legality, final frame:
  - ball1 ≤ PINS
  - after a ball1 strike: ball2 ≤ PINS; ball3 ≤ PINS if ball2 was a strike, else ball3 ≤ PINS−ball2
  - with no ball1 strike: ball2 ≤ PINS−ball1; ball3 is played only on a spare, with ball3 ≤ PINS.
- Turn order:
  - when a frame ends, `cur_player` advances; it wraps from PLAYERS−1 to 0, incrementing `cur_frame`
  - when the last player completes frame FRAMES, `game_over` sets and the position holds.
- Rejected roll (pin_count above the allowed limit, or `game_over`=1):
  - `roll_error` pulses
  - no state changes.
- The running score counts bonuses as the bonus balls arrive. At `game_over` it equals the standard final score.

## Timing
- Reset/new_game values:
  - score=0, roll_error=0, cur_player=0, cur_frame=1, cur_ball=1, game_over=0
  - all totals and multipliers = 0.
- A roll sampled at edge N updates totals and position at edge N. `roll_error`, `cur_*` and `game_over` are visible after edge N.
- `score` register samples total[score_sel] every edge:
  - a roll at edge N appears on `score` after edge N+1
  - a change of `score_sel` is reflected after one edge.
- Back-to-back rolls on consecutive cycles are legal; there is no stall or handshake.
- `new_game` and `roll` high in the same cycle: the roll is discarded with no `roll_error`.
- Reset asserted mid-game: outputs go to reset values immediately, without waiting for a clock edge.
- A `score_sel` of PLAYERS or more yields score=0.
- No overflow is possible when SCORE_W meets its constraint.

## Test plan
- Reset: after reset, score=0, cur_player=0, cur_frame=1, cur_ball=1, game_over=0, roll_error=0.
- PLAYERS=1 score cases, each read two edges after its last roll:
  - 12 strikes → score=300 and game_over=1 after the 12th roll
  - 8, then 19×0 → 8
  - 5,5,5, then 17×0 → 20
  - 10,3,4, then 16×0 → 24.
- Illegal roll: in frame 1, roll 7, then 4 → roll_error pulse, cur_ball stays 2. Then roll 3 → accepted as a spare; the next roll of 5 leaves score=20.
- PLAYERS=2 interleave:
  - P0 rolls 10 → cur_player=1, cur_frame=1
  - P1 rolls 3,4 → cur_player=0, cur_frame=2
  - P0 rolls 2,3 → score_sel=0 gives 20, score_sel=1 gives 7.
- Final frame (PLAYERS=1):
  - 18×0 then 10,10,10 → 30, game_over=1; one more roll → roll_error, score stays 30
  - 18×0 then 9,1,5 → 15; 18×0 then 3,4 → game_over after ball 2, score 7.
- Mid-game clear: `new_game` asserted during frame 5 together with `roll` → all outputs at reset values, no roll_error; then an async reset pulse with no clock edge clears state immediately.
